equiv_check_sequencer: RTL and testbench
========================================

EQUIV_CHECK_SEQUENCER -- requirements
Module: equiv_check_sequencer

Interface
REQ-001 SHALL have parameter: LAT, 1, cycles from a stimulus vector being driven to the y_1/y_2 result being compared; legal range 1..8.
REQ-002 SHALL have parameter: STOP_ON_FAIL, 1, when 1 stop issuing vectors at the first mismatch.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  one-cycle run request.
REQ-006 SHALL have port: seed  input  32  LFSR seed, sampled on accepted start.
REQ-007 SHALL have port: num_vec  input  16  vector count, sampled on accepted start.
REQ-008 SHALL have ports: wire0 output 22, wire1 output 21, wire2 output 21, wire3 output 13; stimulus buses to both DUT copies.
REQ-009 SHALL have ports: y_1 input 91 and y_2 input 91; DUT copy outputs.
REQ-010 SHALL have ports: busy output 1, done output 1 (pulse), pass output 1, mismatch_cnt output 16, fail_idx output 16.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-012 IDLE->RUN on start=1. An effective seed of 0 SHALL be replaced by 32'h0000_0001. Transition SHALL clear mismatch_cnt and set fail_idx=16'hFFFF.
REQ-013 start=1 with num_vec=0 SHALL go IDLE->DONE and report pass=1, mismatch_cnt=0.
REQ-014 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-015 LFSR SHALL be 32-bit Galois, polynomial 0x80200003, shifting right, one step per issued vector. The first vector SHALL use the seed state itself.
REQ-016 For LFSR state S, W SHALL be the 96-bit word {S, S rotated left by 16, ~S}. Mapping: wire0=W[21:0], wire1=W[42:22], wire2=W[63:43], wire3=W[76:64].
REQ-017 In RUN, vector k (0..num_vec-1) SHALL appear on the wire buses in the k-th RUN cycle. RUN SHALL last exactly num_vec cycles, then go to DRAIN.
REQ-018 The wire buses SHALL hold their last value outside RUN.
REQ-019 A LAT-deep valid/index shift pipeline SHALL tag each vector. When tag k exits the pipeline, y_1 SHALL be compared to y_2 (all 91 bits) in that cycle.
REQ-020 On a mismatch, mismatch_cnt SHALL increment, saturating at 16'hFFFF. On the first mismatch of a run, fail_idx SHALL be set to k.
REQ-021 STOP_ON_FAIL=1: on a mismatch, RUN SHALL stop issuing and go to DRAIN. Vectors already in flight SHALL still be compared and counted.
REQ-022 DRAIN SHALL last until the pipeline holds no valid tag, then go to DONE.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE. done=1 only in DONE.
REQ-024 pass SHALL be updated when entering DONE to (mismatch_cnt==0 including the final compare). pass SHALL hold until the next accepted start, which clears it to 0.
REQ-025 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-026 The index counter SHALL be 16 bits. num_vec=16'hFFFF SHALL issue 65535 vectors with no wrap.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and clear the valid pipeline.
REQ-028 On reset: LFSR=32'h1; wire0..wire3=0; busy=0, done=0, pass=0, mismatch_cnt=0; fail_idx=16'hFFFF.
REQ-029 Reset during RUN or DRAIN SHALL abort with no done pulse.
REQ-030 The first start after reset release SHALL behave identically to a cold start.

Structure
REQ-031 The shared package equiv_pkg SHALL hold: the FSM state enum, LFSR_POLY, Y_W=91, the stimulus widths (22/21/21/13), and FAIL_IDX_NONE=16'hFFFF.
REQ-032 The LFSR plus W-mapping SHALL be one sub-module, equiv_stim_lfsr, with ports clk, rst_n, load, seed, step, and the wire outputs.

Verification
REQ-033 LAT=1; y_1=y_2 tied; seed=0x1, num_vec=4 -> wire0 first = 22'h000001; done exactly 6 cycles after start; pass=1, mismatch_cnt=0.
REQ-034 LAT=3; y_2 = y_1 XOR bit0 only for vector 5; num_vec=10; STOP_ON_FAIL=0 -> mismatch_cnt=1, fail_idx=5, pass=0, all 10 vectors issued.
REQ-035 Same stimulus with STOP_ON_FAIL=1 -> issuing stops after at most vector 7, fail_idx=5, done after drain.
REQ-036 num_vec=0 -> done on the cycle after start, pass=1; start asserted during busy -> no effect on counts.
REQ-037 rst_n pulse mid-RUN -> outputs return to reset values and no done pulse; a following start with seed=0 behaves as seed=1.
REQ-038 y_2 = ~y_1 for all vectors; num_vec=16'hFFFF; STOP_ON_FAIL=0 -> mismatch_cnt=16'hFFFF (saturated), fail_idx=0.

Source files
------------

// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared types, widths and LFSR helper for the equivalence-check sequencer
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] SEED_DEFAULT  = 32'h0000_0001;
  localparam int          Y_W           = 91;
  localparam int          W0_W          = 22;
  localparam int          W1_W          = 21;
  localparam int          W2_W          = 21;
  localparam int          W3_W          = 13;
  localparam logic [15:0] FAIL_IDX_NONE = 16'hFFFF;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/equiv_stim_lfsr.sv
// rtl/equiv_stim_lfsr.sv - LFSR stimulus generator mapping its state onto the four wire buses
//   clk, rst_n      : clock, asynchronous active-low reset
//   load, seed      : load seed as the current vector state (wins over step)
//   step            : advance the LFSR one step and present the new vector
//   wire0..wire3    : registered stimulus buses; they only change on load/step
module equiv_stim_lfsr
  import equiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [31:0]     seed,
  input  logic            step,
  output logic [W0_W-1:0] wire0,
  output logic [W1_W-1:0] wire1,
  output logic [W2_W-1:0] wire2,
  output logic [W3_W-1:0] wire3
);

  logic [31:0]     lfsr_q, lfsr_d;
  logic [W0_W-1:0] wire0_q, wire0_d;
  logic [W1_W-1:0] wire1_q, wire1_d;
  logic [W2_W-1:0] wire2_q, wire2_d;
  logic [W3_W-1:0] wire3_q, wire3_d;
  logic            upd;
  logic [31:0]     s_new;
  logic [76:0]     w;

  always_comb begin
    s_new = lfsr_q;
    upd   = 1'b0;
    if (load) begin
      s_new = seed;
      upd   = 1'b1;
    end else if (step) begin
      s_new = lfsr_next(lfsr_q);
      upd   = 1'b1;
    end
    lfsr_d = s_new;
    // Low 77 bits of the stimulus word: S in the low word, S rotated left
    // by 16 above it, then the bottom of ~S. wire0 therefore carries S[21:0].
    w = {~s_new[12:0], s_new[15:0], s_new[31:16], s_new};
    wire0_d = upd ? w[21:0]  : wire0_q;
    wire1_d = upd ? w[42:22] : wire1_q;
    wire2_d = upd ? w[63:43] : wire2_q;
    wire3_d = upd ? w[76:64] : wire3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= SEED_DEFAULT;
      wire0_q <= '0;
      wire1_q <= '0;
      wire2_q <= '0;
      wire3_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      wire0_q <= wire0_d;
      wire1_q <= wire1_d;
      wire2_q <= wire2_d;
      wire3_q <= wire3_d;
    end
  end

  assign wire0 = wire0_q;
  assign wire1 = wire1_q;
  assign wire2 = wire2_q;
  assign wire3 = wire3_q;

endmodule

// File: rtl/equiv_check_sequencer.sv
// rtl/equiv_check_sequencer.sv - drives LFSR vectors into two design copies and compares their outputs
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, seed, num_vec: run request; seed/num_vec sampled when start is accepted in IDLE
//   wire0..wire3        : stimulus buses shared by both design copies
//   y_1, y_2            : design copy outputs, compared LAT-1 cycles after the vector is driven
//   busy, done, pass    : run status (done is a one-cycle pulse)
//   mismatch_cnt        : saturating mismatch count of the current/last run
//   fail_idx            : index of the first mismatching vector, 16'hFFFF if none
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int LAT          = 1,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     seed,
  input  logic [15:0]     num_vec,
  output logic [W0_W-1:0] wire0,
  output logic [W1_W-1:0] wire1,
  output logic [W2_W-1:0] wire2,
  output logic [W3_W-1:0] wire3,
  input  logic [Y_W-1:0]  y_1,
  input  logic [Y_W-1:0]  y_2,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     mismatch_cnt,
  output logic [15:0]     fail_idx
);

  state_e          state_q, state_d;
  logic [15:0]     last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     fail_q, fail_d;
  logic            pass_q, pass_d;
  // Stage 0 is loaded on the same edge as the wire buses, so it tags the
  // vector currently being driven; stage LAT-1 is the one being compared.
  logic [LAT-1:0]  vld_q, vld_d;
  logic [15:0]     tag_q [LAT];
  logic [15:0]     tag_d [LAT];

  logic            load, step, issue, cmp_hit;
  logic [15:0]     issue_idx;
  logic [31:0]     seed_eff;

  assign seed_eff = (seed == 32'h0) ? SEED_DEFAULT : seed;
  assign cmp_hit  = vld_q[LAT-1] && (y_1 != y_2);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    load      = 1'b0;
    step      = 1'b0;
    issue     = 1'b0;
    issue_idx = tag_q[0];

    if (cmp_hit) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      // The count never returns to zero within a run, so zero means first mismatch.
      if (cnt_q == 16'h0) fail_d = tag_q[LAT-1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = 16'h0;
          fail_d = FAIL_IDX_NONE;
          pass_d = 1'b0;
          if (num_vec == 16'h0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            load      = 1'b1;
            issue     = 1'b1;
            issue_idx = 16'h0;
            last_d    = num_vec - 16'd1;
          end
        end
      end
      ST_RUN: begin
        if ((STOP_ON_FAIL && cmp_hit) || (tag_q[0] == last_q)) begin
          state_d = ST_DRAIN;
        end else begin
          step      = 1'b1;
          issue     = 1'b1;
          issue_idx = tag_q[0] + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (vld_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (cnt_d == 16'h0);

    vld_d[0] = issue;
    tag_d[0] = issue_idx;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 16'h0;
      cnt_q   <= 16'h0;
      fail_q  <= FAIL_IDX_NONE;
      pass_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= 16'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      vld_q   <= vld_d;
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  equiv_stim_lfsr u_stim (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (seed_eff),
    .step  (step),
    .wire0 (wire0),
    .wire1 (wire1),
    .wire2 (wire2),
    .wire3 (wire3)
  );

  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign pass         = pass_q;
  assign mismatch_cnt = cnt_q;
  assign fail_idx     = fail_q;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// tb/tb_equiv_check_sequencer.sv - randomized self-checking bench for equiv_check_sequencer
module tb_equiv_check_sequencer;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seed;
  logic [15:0] num_vec;
  logic        start_a [NI];
  logic [21:0] w0_a [NI];
  logic [20:0] w1_a [NI];
  logic [20:0] w2_a [NI];
  logic [12:0] w3_a [NI];
  logic [90:0] y1_a [NI];
  logic [90:0] y2_a [NI];
  logic        busy_a [NI];
  logic        done_a [NI];
  logic        pass_a [NI];
  logic [15:0] cnt_a [NI];
  logic [15:0] fidx_a [NI];

  logic [76:0] bun_a [NI];
  logic [76:0] d1_a [NI];
  logic [76:0] d2_a [NI];
  logic [76:0] dl_a [NI];
  logic        hit_a [NI];

  logic [76:0] bad_w [4];
  int          bad_idx [4];
  int          bad_n = 0;
  bit          inv_all = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [21:0] first_w0;
  int          done_seen;

  always #5 clk = ~clk;

  equiv_check_sequencer #(.LAT(1), .STOP_ON_FAIL(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .seed(seed), .num_vec(num_vec),
    .wire0(w0_a[0]), .wire1(w1_a[0]), .wire2(w2_a[0]), .wire3(w3_a[0]),
    .y_1(y1_a[0]), .y_2(y2_a[0]), .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]),
    .mismatch_cnt(cnt_a[0]), .fail_idx(fidx_a[0]));
  equiv_check_sequencer #(.LAT(3), .STOP_ON_FAIL(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .seed(seed), .num_vec(num_vec),
    .wire0(w0_a[1]), .wire1(w1_a[1]), .wire2(w2_a[1]), .wire3(w3_a[1]),
    .y_1(y1_a[1]), .y_2(y2_a[1]), .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]),
    .mismatch_cnt(cnt_a[1]), .fail_idx(fidx_a[1]));
  equiv_check_sequencer #(.LAT(3), .STOP_ON_FAIL(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .seed(seed), .num_vec(num_vec),
    .wire0(w0_a[2]), .wire1(w1_a[2]), .wire2(w2_a[2]), .wire3(w3_a[2]),
    .y_1(y1_a[2]), .y_2(y2_a[2]), .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]),
    .mismatch_cnt(cnt_a[2]), .fail_idx(fidx_a[2]));

  // Design-copy model: y is a fixed function of the vector seen LAT-1 cycles earlier.
  always_comb begin
    for (int i = 0; i < NI; i++) bun_a[i] = {w3_a[i], w2_a[i], w1_a[i], w0_a[i]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      d1_a[i] <= bun_a[i];
      d2_a[i] <= d1_a[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) dl_a[i] = (i == 0) ? bun_a[i] : d2_a[i];
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      hit_a[i] = 1'b0;
      for (int j = 0; j < 4; j++)
        if (j < bad_n && bad_w[j] == dl_a[i]) hit_a[i] = 1'b1;
      y1_a[i] = {dl_a[i][13:0], dl_a[i]};
      y2_a[i] = inv_all ? ~{dl_a[i][13:0], dl_a[i]} :
                (hit_a[i] ? ({dl_a[i][13:0], dl_a[i]} ^ 91'd1) : {dl_a[i][13:0], dl_a[i]});
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit sof_of(input int i);
    return (i == 2);
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [76:0] ref_wires(input logic [31:0] s);
    logic [95:0] w;
    w[31:0]  = s;
    w[63:32] = (s << 16) | (s >> 16);
    w[95:64] = ~s;
    return {w[76:64], w[63:43], w[42:22], w[21:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run on instance i, every cycle checked against the reference outcome.
  task automatic run_case(input int i, input logic [31:0] sd, input logic [15:0] n, input bit poke);
    logic [31:0] eff, s;
    logic [76:0] prev, lastw, expw;
    int lat, first_bad, issued, ecnt, edone, cyc;
    logic [15:0] efail;
    bit epass, sof;
    eff = (sd == 32'h0) ? 32'h1 : sd;
    lat = lat_of(i);
    sof = sof_of(i);
    first_bad = 65536;
    if (inv_all) first_bad = 0;
    else for (int j = 0; j < bad_n; j++) if (bad_idx[j] < first_bad) first_bad = bad_idx[j];
    issued = n;
    if (sof && first_bad + lat < int'(n)) issued = first_bad + lat;
    ecnt = 0;
    if (inv_all) ecnt = issued;
    else for (int j = 0; j < bad_n; j++) if (bad_idx[j] < issued) ecnt++;
    if (ecnt > 65535) ecnt = 65535;
    efail = (ecnt == 0) ? 16'hFFFF : 16'(first_bad);
    epass = (ecnt == 0);
    edone = (n == 0) ? 1 : issued + lat + 1;
    for (int j = 0; j < bad_n; j++) begin
      s = eff;
      for (int k = 0; k < bad_idx[j]; k++) s = ref_step(s);
      bad_w[j] = ref_wires(s);
    end
    prev = bun_a[i];
    lastw = prev;
    done_seen = -1;
    seed = sd;
    num_vec = n;
    start_a[i] = 1'b1;
    tick();
    start_a[i] = 1'b0;
    first_w0 = w0_a[i];
    s = eff;
    for (cyc = 1; cyc <= edone + 1; cyc++) begin
      if (done_a[i] === 1'b1 && done_seen < 0) done_seen = cyc;
      vectors++;
      if (done_a[i] !== (cyc == edone)) begin
        miscompares++;
        $display("FAIL done[%0d] inst%0d cyc%0d: got %b want %b", i, i, cyc, done_a[i], cyc == edone);
      end
      vectors++;
      if (busy_a[i] !== (n != 0 && cyc < edone)) begin
        miscompares++;
        $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, cyc, busy_a[i], n != 0 && cyc < edone);
      end
      if (cyc <= issued) begin
        expw = ref_wires(s);
        lastw = expw;
        s = ref_step(s);
      end else begin
        expw = (n == 0) ? prev : lastw;
      end
      vectors++;
      if (bun_a[i] !== expw) begin
        miscompares++;
        $display("FAIL wires inst%0d cyc%0d: got %h want %h", i, cyc, bun_a[i], expw);
      end
      if (cyc == edone) begin
        vectors += 3;
        if (pass_a[i] !== epass) begin
          miscompares++;
          $display("FAIL pass inst%0d: got %b want %b", i, pass_a[i], epass);
        end
        if (cnt_a[i] !== 16'(ecnt)) begin
          miscompares++;
          $display("FAIL mismatch_cnt inst%0d: got %0h want %0h", i, cnt_a[i], ecnt);
        end
        if (fidx_a[i] !== efail) begin
          miscompares++;
          $display("FAIL fail_idx inst%0d: got %0h want %0h", i, fidx_a[i], efail);
        end
      end
      if (poke && cyc == 2) begin
        seed = ~sd;
        num_vec = n + 16'd5;
        start_a[i] = 1'b1;
      end
      if (poke && cyc == 3) begin
        start_a[i] = 1'b0;
        seed = sd;
        num_vec = n;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seed = 32'h0;
    num_vec = 16'h0;
    for (int i = 0; i < NI; i++) start_a[i] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if ({bun_a[i], busy_a[i], done_a[i], pass_a[i], cnt_a[i], fidx_a[i]} !==
          {77'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF}) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: got w=%h b=%b d=%b p=%b c=%h f=%h want zeros, fail_idx ffff",
                 i, bun_a[i], busy_a[i], done_a[i], pass_a[i], cnt_a[i], fidx_a[i]);
      end
    end
  endtask

  task automatic test_basic();
    bad_n = 0;
    run_case(0, 32'h1, 16'd4, 1'b0);
    vectors += 2;
    if (first_w0 !== 22'h000001) begin
      miscompares++;
      $display("FAIL first_wire0: got %h want 000001", first_w0);
    end
    if (done_seen != 6) begin
      miscompares++;
      $display("FAIL done_latency: got %0d want 6", done_seen);
    end
  endtask

  task automatic test_single_fail();
    logic [31:0] sd;
    sd = $urandom;
    bad_n = 1;
    bad_idx[0] = 5;
    run_case(1, sd, 16'd10, 1'b0);
    run_case(2, sd, 16'd10, 1'b0);
    bad_n = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      bad_n = $urandom_range(0, 3);
      for (int j = 0; j < 4; j++) bad_idx[j] = j * 15 + $urandom_range(0, 14);
      run_case(r % NI, $urandom, 16'($urandom_range(1, 40)), r[0]);
    end
    bad_n = 0;
  endtask

  task automatic test_zero_vec();
    for (int i = 0; i < NI; i++) begin
      run_case(i, $urandom, 16'd0, 1'b0);
      vectors++;
      if (done_seen != 1) begin
        miscompares++;
        $display("FAIL zero_vec_done inst%0d: got %0d want 1", i, done_seen);
      end
    end
  endtask

  task automatic test_start_during_busy();
    bad_n = 1;
    bad_idx[0] = 3;
    run_case(1, $urandom, 16'd12, 1'b1);
    run_case(2, $urandom, 16'd12, 1'b1);
    bad_n = 0;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bad_n = 0;
    seed = $urandom;
    num_vec = 16'd20;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bun_a[0], busy_a[0], done_a[0], pass_a[0], cnt_a[0], fidx_a[0]} !==
        {77'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got w=%h b=%b d=%b p=%b c=%h f=%h want reset values",
               bun_a[0], busy_a[0], done_a[0], pass_a[0], cnt_a[0], fidx_a[0]);
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (done_a[0] === 1'b1 || busy_a[0] === 1'b1) seen++;
      tick();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
    end
    run_case(0, 32'h0, 16'd7, 1'b0);
    vectors++;
    if (first_w0 !== 22'h000001) begin
      miscompares++;
      $display("FAIL seed0_as_seed1: got %h want 000001", first_w0);
    end
  endtask

  task automatic test_saturate();
    bad_n = 0;
    inv_all = 1'b1;
    run_case(0, $urandom, 16'hFFFF, 1'b0);
    inv_all = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_fail();
    test_zero_vec();
    test_start_during_busy();
    test_random();
    test_reset_mid_run();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
